// File: rtl/ram_bank.sv
// Bank of 4002-style RAM/status/output-port chips on the 4004 nibble bus,
// with a 32-bit Wishbone backdoor serviced once per 8-clock instruction cycle.
module ram_bank #(
  parameter int NUM_CHIPS = 4,
  parameter int NUM_REGS  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  inout  wire  [3:0]             data,
  input  logic                   sync,
  input  logic                   cmd_n,
  output logic [4*NUM_CHIPS-1:0] out,
  input  logic [31:0]            wb_data_i,
  input  logic [31:0]            wb_addr_i,
  input  logic [3:0]             wb_sel_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_strobe_i,
  input  logic                   wb_we_i,
  output logic [31:0]            wb_data_o,
  output logic                   wb_ack_o
);

  localparam logic [2:0] CHIPS_L    = 3'(NUM_CHIPS);
  localparam logic [2:0] REGS_L     = 3'(NUM_REGS);
  localparam logic [6:0] RAM_WORDS  = 7'(NUM_CHIPS * 8);
  localparam logic [6:0] STAT_WORDS = 7'(NUM_CHIPS * 2);

  logic [2:0] cycle_reg;
  logic [1:0] chip_reg;
  logic [1:0] reg_reg;
  logic [3:0] char_reg;
  logic [3:0] inst_reg;
  logic       selected_reg;
  logic       src_active_reg;
  logic       inst_active_reg;

  // Storage is sized for the largest bank; flat index = {chip, reg, char/idx}.
  logic [3:0] ram_mem  [256];
  logic [3:0] stat_mem [64];
  logic [3:0] port_reg [4];

  logic [3:0]  bus_in;
  logic        cmd;
  logic        src_hit;
  logic [7:0]  ram_idx;
  logic [5:0]  stat_idx;
  logic        drive_en;
  logic [3:0]  drive_val;
  logic [1:0]  region;
  logic [5:0]  word;
  logic        ram_ok;
  logic        stat_ok;
  logic        port_ok;
  logic        wb_fire;
  logic [31:0] port_word;
  logic [31:0] rd_word;
  logic        unused_ok;

  assign bus_in   = data;
  assign cmd      = !cmd_n;
  assign src_hit  = ({1'b0, bus_in[3:2]} < CHIPS_L) && ({1'b0, bus_in[1:0]} < REGS_L);
  assign ram_idx  = {chip_reg, reg_reg, char_reg};
  assign stat_idx = {chip_reg, reg_reg, inst_reg[1:0]};

  always_comb begin
    drive_en  = 1'b0;
    drive_val = 4'h0;
    if (cycle_reg == 3'd6 && inst_active_reg) begin
      case (inst_reg)
        4'h8, 4'h9, 4'hB: begin
          drive_en  = 1'b1;
          drive_val = ram_mem[ram_idx];
        end
        4'hC, 4'hD, 4'hE, 4'hF: begin
          drive_en  = 1'b1;
          drive_val = stat_mem[stat_idx];
        end
        default: ;
      endcase
    end
  end

  assign data = drive_en ? drive_val : 4'bz;

  assign region  = wb_addr_i[9:8];
  assign word    = wb_addr_i[7:2];
  assign ram_ok  = (region == 2'd0) && ({1'b0, word} < RAM_WORDS);
  assign stat_ok = (region == 2'd1) && ({1'b0, word} < STAT_WORDS);
  assign port_ok = (region == 2'd2) && (word == 6'd0);
  assign wb_fire = (cycle_reg == 3'd7) && wb_cyc_i && wb_strobe_i && !wb_ack_o;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      assign port_word[4*gi +: 4] = (gi < NUM_CHIPS) ? port_reg[gi] : 4'h0;
    end
    for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_out
      assign out[4*gi +: 4] = port_reg[gi];
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_rd
      assign rd_word[4*gi +: 4] = ram_ok  ? ram_mem[{word[4:0], 3'(gi)}] :
                                  stat_ok ? stat_mem[{word[2:0], 3'(gi)}] :
                                  port_ok ? port_word[4*gi +: 4] : 4'h0;
    end
  endgenerate
  assign port_word[31:16] = 16'h0;

  // Bus phase comes from the free-running counter, so sync is not needed.
  assign unused_ok = ^{sync, wb_addr_i[31:10], wb_addr_i[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_reg       <= 3'd0;
      chip_reg        <= 2'd0;
      reg_reg         <= 2'(NUM_REGS - 1);
      char_reg        <= 4'hF;
      inst_reg        <= 4'h0;
      selected_reg    <= 1'b0;
      src_active_reg  <= 1'b0;
      inst_active_reg <= 1'b0;
      wb_ack_o        <= 1'b0;
      wb_data_o       <= 32'h0;
      for (int i = 0; i < 256; i++) ram_mem[i] <= 4'h0;
      for (int i = 0; i < 64; i++) stat_mem[i] <= 4'h0;
      for (int i = 0; i < 4; i++) port_reg[i] <= 4'h0;
    end else begin
      cycle_reg <= cycle_reg + 3'd1;
      wb_ack_o  <= 1'b0;

      if (cmd && cycle_reg == 3'd6) begin
        if (src_hit) begin
          chip_reg       <= bus_in[3:2];
          reg_reg        <= bus_in[1:0];
          selected_reg   <= 1'b1;
          src_active_reg <= 1'b1;
        end else begin
          selected_reg <= 1'b0;
        end
      end

      if (!cmd && cycle_reg == 3'd7) begin
        inst_active_reg <= 1'b0;
        if (src_active_reg) begin
          char_reg       <= bus_in;
          src_active_reg <= 1'b0;
        end
      end

      if (cmd && cycle_reg == 3'd4 && selected_reg) begin
        inst_reg        <= bus_in;
        inst_active_reg <= 1'b1;
      end

      if (cycle_reg == 3'd6 && inst_active_reg) begin
        case (inst_reg)
          4'h0:                   ram_mem[ram_idx]   <= bus_in;
          4'h1:                   port_reg[chip_reg] <= bus_in;
          4'h4, 4'h5, 4'h6, 4'h7: stat_mem[stat_idx] <= bus_in;
          default: ;
        endcase
      end

      // Backdoor runs only at cycle 7, so it never collides with CPU writes.
      if (wb_fire) begin
        wb_ack_o  <= 1'b1;
        wb_data_o <= rd_word;
        if (wb_we_i) begin
          for (int k = 0; k < 8; k++) begin
            if (wb_sel_i[k/2]) begin
              if (ram_ok) ram_mem[{word[4:0], 3'(k)}] <= wb_data_i[4*k +: 4];
              if (stat_ok) stat_mem[{word[2:0], 3'(k)}] <= wb_data_i[4*k +: 4];
              if (port_ok && k < NUM_CHIPS) port_reg[2'(k)] <= wb_data_i[4*k +: 4];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: a 4-chip and a 2-chip bank on twin pulled-up buses,
// with expected bus/backdoor results queued when stimulus is issued.
module tb_ram_bank;

  logic        clock = 1'b0;
  logic        reset;
  logic        sync;
  logic        cmd_n;
  logic [31:0] wb_data_i;
  logic [31:0] wb_addr_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_strobe_i;
  logic        wb_we_i;
  logic [3:0]  cpu_data;
  logic        cpu_en;
  tri   [3:0]  data4;
  tri   [3:0]  data2;
  logic [15:0] out4;
  logic [7:0]  out2;
  logic [31:0] wb_data_o4;
  logic [31:0] wb_data_o2;
  logic        wb_ack_o4;
  logic        wb_ack_o2;
  logic [2:0]  phase;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_exp4 [$];
  logic [31:0] sb_exp2 [$];
  string       sb_tag  [$];

  always #5 clock = ~clock;
  always @(posedge clock) phase <= reset ? 3'd0 : phase + 3'd1;

  // An undriven bus reads back as F through the pullups.
  assign data4 = cpu_en ? cpu_data : 4'bz;
  assign data2 = cpu_en ? cpu_data : 4'bz;
  for (genvar gi = 0; gi < 4; gi++) begin : g_pu
    pullup (data4[gi]);
    pullup (data2[gi]);
  end

  ram_bank dut4 (
    .clock(clock), .reset(reset), .data(data4), .sync(sync), .cmd_n(cmd_n), .out(out4),
    .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i),
    .wb_strobe_i(wb_strobe_i), .wb_we_i(wb_we_i), .wb_data_o(wb_data_o4), .wb_ack_o(wb_ack_o4)
  );

  ram_bank #(.NUM_CHIPS(2), .NUM_REGS(4)) dut2 (
    .clock(clock), .reset(reset), .data(data2), .sync(sync), .cmd_n(cmd_n), .out(out2),
    .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i),
    .wb_strobe_i(wb_strobe_i), .wb_we_i(wb_we_i), .wb_data_o(wb_data_o2), .wb_ack_o(wb_ack_o2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic align();
    while (phase != 3'd0) @(negedge clock);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] e4, input logic [31:0] e2);
    sb_tag.push_back(tag);
    sb_exp4.push_back(e4);
    sb_exp2.push_back(e2);
  endtask

  // One 8-clock instruction cycle; each iteration drives the signals for phase p.
  task automatic bus_cycle(input logic cm4, input logic [3:0] d4, input logic cm6,
                           input logic [3:0] d6, input logic drv6, input logic [3:0] d7,
                           input logic drv7, input logic rd6);
    string t;
    align();
    for (int p = 0; p < 8; p++) begin
      cmd_n    = !((p == 4 && cm4) || (p == 6 && cm6));
      cpu_en   = (p == 4 && cm4) || (p == 6 && drv6) || (p == 7 && drv7);
      cpu_data = (p == 4) ? d4 : (p == 6) ? d6 : d7;
      if (p == 6 && rd6 && sb_tag.size() > 0) begin
        #1;
        t = sb_tag.pop_front();
        check({t, "_data4"}, 32'(data4), sb_exp4.pop_front());
        check({t, "_data2"}, 32'(data2), sb_exp2.pop_front());
      end
      @(negedge clock);
    end
    cmd_n  = 1'b1;
    cpu_en = 1'b0;
  endtask

  task automatic src(input logic [1:0] chip, input logic [1:0] rg, input logic [3:0] chr);
    bus_cycle(1'b0, 4'h0, 1'b1, {chip, rg}, 1'b1, chr, 1'b1, 1'b0);
  endtask

  task automatic wr_io(input logic [3:0] inst, input logic [3:0] val);
    bus_cycle(1'b1, inst, 1'b0, val, 1'b1, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic rd_io(input string tag, input logic [3:0] inst, input logic [3:0] e4,
                       input logic [3:0] e2);
    sb_push(tag, 32'(e4), 32'(e2));
    bus_cycle(1'b1, inst, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic wb_xfer(input string tag, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdat, input logic [3:0] sel,
                         input logic [31:0] e4, input logic [31:0] e2);
    int    n;
    string t;
    sb_push(tag, e4, e2);
    align();
    wb_addr_i = addr; wb_we_i = we; wb_data_i = wdat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_strobe_i = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!wb_ack_o4 && n < 16);
    t = sb_tag.pop_front();
    check({t, "_ack4"}, 32'(wb_ack_o4), 32'd1);
    check({t, "_ack2"}, 32'(wb_ack_o2), 32'd1);
    check({t, "_lat"}, 32'(n), 32'd8);
    check({t, "_dat4"}, wb_data_o4, sb_exp4.pop_front());
    check({t, "_dat2"}, wb_data_o2, sb_exp2.pop_front());
    wb_cyc_i = 1'b0; wb_strobe_i = 1'b0; wb_we_i = 1'b0;
    align();
  endtask

  initial begin
    int    acks;
    int    last;
    logic  prev;
    string t;

    reset = 1'b1; sync = 1'b0; cmd_n = 1'b1; cpu_en = 1'b0; cpu_data = 4'h0;
    wb_data_i = 32'h0; wb_addr_i = 32'h0; wb_sel_i = 4'h0;
    wb_cyc_i = 1'b0; wb_strobe_i = 1'b0; wb_we_i = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    check("rst_out4", 32'(out4), 32'h0);
    check("rst_out2", 32'(out2), 32'h0);
    check("rst_ack4", 32'(wb_ack_o4), 32'h0);
    check("rst_dato4", wb_data_o4, 32'h0);
    check("rst_bus4", 32'(data4), 32'hF);
    check("rst_bus2", 32'(data2), 32'hF);
    for (int w = 0; w < 32; w++) wb_xfer("rst_ram", 32'(w) << 2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    for (int w = 0; w < 8; w++) wb_xfer("rst_stat", 32'h100 | (32'(w) << 2), 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);

    // CPU RAM round trip on chip 2 reg 1 char 5 (absent in the 2-chip bank).
    src(2'd2, 2'd1, 4'h5);
    wr_io(4'h0, 4'hA);
    wb_xfer("ram_w18", 32'h48, 1'b0, 32'h0, 4'h0, 32'h00A00000, 32'h0);
    rd_io("rdm_a", 4'h9, 4'hA, 4'hF);

    // Status write: chip 1 reg 0 idx 3 -> flat 19 -> word 2 nibble 3.
    src(2'd1, 2'd0, 4'h0);
    wr_io(4'h7, 4'h7);
    wb_xfer("stat_w2", 32'h108, 1'b0, 32'h0, 4'h0, 32'h00007000, 32'h00007000);

    // Chip 3: output port in the 4-chip bank, deselects the 2-chip bank.
    src(2'd3, 2'd0, 4'h0);
    wr_io(4'h1, 4'hC);
    check("wmp_out4", 32'(out4), 32'h0000C000);
    check("wmp_out2", 32'(out2), 32'h0);
    rd_io("rd3_c3", 4'hF, 4'h0, 4'hF);
    wb_xfer("port_w0", 32'h200, 1'b0, 32'h0, 4'h0, 32'h0000C000, 32'h0);

    // Byte lane 1 only: nibbles 2,3 take 3,4; the write returns prior contents.
    wb_xfer("lane_wr", 32'h0, 1'b1, 32'h87654321, 4'b0010, 32'h0, 32'h0);
    wb_xfer("lane_rd", 32'h0, 1'b0, 32'h0, 4'h0, 32'h00004300, 32'h00004300);
    src(2'd0, 2'd0, 4'h2);
    rd_io("rdm_lane", 4'h9, 4'h3, 4'h3);

    // Word 16 exists only in the 4-chip bank; region 3 is always empty.
    wb_xfer("w16_wr", 32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 32'h0);
    wb_xfer("w16_rd", 32'h40, 1'b0, 32'h0, 4'h0, 32'hFFFFFFFF, 32'h0);
    wb_xfer("r3_wr", 32'h300, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 32'h0);
    wb_xfer("r3_rd", 32'h300, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);

    // Strobe held for three instruction cycles: one-clock acks, 8 clocks apart.
    for (int i = 0; i < 3; i++) sb_push("hold", 32'h0000C000, 32'h0);
    align();
    wb_addr_i = 32'h200; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_strobe_i = 1'b1;
    acks = 0; last = -1; prev = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clock);
      if (wb_ack_o4) begin
        acks++;
        check("hold_phase", 32'(phase), 32'd0);
        check("hold_width", 32'(prev), 32'd0);
        if (last >= 0) check("hold_gap", 32'(n - last), 32'd8);
        last = n;
        if (sb_tag.size() > 0) begin
          t = sb_tag.pop_front();
          check({t, "_dat4"}, wb_data_o4, sb_exp4.pop_front());
          check({t, "_dat2"}, wb_data_o2, sb_exp2.pop_front());
        end
      end
      prev = wb_ack_o4;
    end
    check("hold_count", 32'(acks), 32'd3);
    wb_cyc_i = 1'b0; wb_strobe_i = 1'b0;
    @(negedge clock);
    check("hold_drop", 32'(wb_ack_o4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bank.md
# ram_bank

Parametrised successor to the single-chip 4002 RAM model. It emulates `NUM_CHIPS` 4002-style RAM/status/output-port chips sharing one CM-RAM line on the 4-bit 4004 bus. It also provides a 32-bit Wishbone backdoor that packs eight nibbles per word and gives read/write access to the output ports. It sits on the CPU data bus beside the ROM model and hangs off the SoC Wishbone interconnect.

## Interface
- `NUM_CHIPS`, default 4: chips emulated, legal values 1..4. A chip is selected when SRC `data[3:2]` < `NUM_CHIPS`.
- `NUM_REGS`, default 4: registers per chip, legal values 1..4. Register index is SRC `data[1:0]`.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `data` inout 4: 4004 data bus.
- `sync` in 1: CPU sync. Unused internally; phase comes from the local counter.
- `cmd_n` in 1: CM-RAM, active low.
- `out` out 4*NUM_CHIPS: output ports. Chip c drives bits `[4c+3:4c]`.
- `wb_data_i` in 32, `wb_addr_i` in 32, `wb_sel_i` in 4, `wb_cyc_i` in 1, `wb_strobe_i` in 1, `wb_we_i` in 1: Wishbone slave inputs.
- `wb_data_o` out 32, `wb_ack_o` out 1: Wishbone slave outputs.

## Operation
- **Phase counter:** `cycle`, 3 bits, 0 after reset, increments every clock and wraps 7→0.
- **Storage per chip:** `NUM_REGS`×16 data nibbles and `NUM_REGS`×4 status nibbles.
  - Flat RAM index = chip*64 + reg*16 + char.
  - Flat status index = chip*16 + reg*4 + idx.
- **SRC, high half** (cmd asserted, cycle 6):
  - If `data[3:2]` < `NUM_CHIPS` and `data[1:0]` < `NUM_REGS`: latch chip, reg; set `selected` and `src_active`.
  - Otherwise: clear `selected`.
- **SRC, low half** (cmd deasserted, cycle 7, `src_active`): latch `char_addr` = `data`, clear `src_active`.
- **I/O instruction capture** (cmd asserted, cycle 4, `selected`): latch `inst` = `data`, set `inst_active`.
- **Cycle 7 with cmd deasserted:** always clears `inst_active`.
- **Execute at cycle 6 when `inst_active`:**
  - 0 WRM: RAM[idx] ← `data`.
  - 1 WMP: `out[chip]` ← `data`.
  - 4–7 WRn: status[n] ← `data`.
  - 8, 9, B (SBM/RDM/ADM): drive `data` = RAM[idx].
  - C–F RDn: drive `data` = status[n].
  - All other codes: no effect.
- **Bus drive:** `data` is high-Z at all other times.
- **Wishbone address map:** `wb_addr_i[1:0]` ignored; region = `wb_addr_i[9:8]`; word = `wb_addr_i[7:2]`.
  - Region 0, RAM: word w holds flat nibbles 8w..8w+7; nibble k sits in bits `[4k+3:4k]`. Valid for w < NUM_CHIPS*8.
  - Region 1, status: same packing. Valid for w < NUM_CHIPS*2.
  - Region 2, output ports: word 0 only; bits `[4c+3:4c]` = `out` of chip c, unused bits read 0.
- **Out-of-range words and region 3:** read 0, writes ignored, still acked.
- **Wishbone write:** byte lane b (`wb_sel_i[b]`) updates nibbles 2b and 2b+1 of the word; other nibbles are unchanged.
- **Wishbone read:** returns the whole word regardless of `wb_sel_i`.

## Timing
- **Reset values:** `cycle`=0, `out`=0, all RAM/status nibbles 0, `wb_ack_o`=0, `wb_data_o`=0, `selected`/`src_active`/`inst_active`=0, reg=NUM_REGS-1, `char_addr`=F.
- **Writes from the CPU bus** land on the clock edge ending cycle 6. A read at cycle 6 sees the value written by any earlier instruction.
- **Wishbone service:**
  - A request is serviced only on the edge ending cycle 7, when `wb_cyc_i & wb_strobe_i & !wb_ack_o`.
  - `wb_data_o` (pre-write contents) and `wb_ack_o` are registered on that edge.
  - `wb_ack_o` is high for exactly one clock.
  - Worst-case latency is 8 clocks.
  - A request still asserted in the cycle after ack is not re-serviced until the next cycle 7.
- **Bus vs backdoor ordering:** CPU writes happen at cycle 6 and backdoor writes at cycle 7, so they never coincide. A backdoor write is visible to a CPU read in the next instruction cycle.
- **Reset mid-transaction:** drops any pending ack, clears all storage, and restarts the phase at 0.

## Test plan
- **Reset:** assert reset for 2 clocks → `out`=0, `wb_ack_o`=0, `data` high-Z, and backdoor reads of every RAM/status word return 0.
- **CPU RAM round-trip:**
  - SRC with chip 2, reg 1, char 5, then WRM of A → backdoor read of region 0, word (2*64+16+5)/8=18, returns A in nibble 5.
  - A following RDM drives `data`=A at cycle 6.
- **Status and output ports:**
  - WR3 of 7 on chip 1, reg 0 → status flat index 19, i.e. word 2 nibble 3, reads 7.
  - WMP of C on chip 3 → `out[15:12]`=C; region 2 word 0 reads 0x0000C000.
- **Backdoor byte-lane write:** write 0x87654321 with `wb_sel_i`=0010 to RAM word 0 → only nibbles 2,3 change to 3,4. A CPU RDM at chip 0, reg 0, char 2 then drives 3.
- **Parameter edge:**
  - `NUM_CHIPS`=2, SRC chip 3 → not selected, no writes, `data` stays high-Z.
  - Backdoor access to RAM word 16 → reads 0 and is acked.
- **Ack timing:** strobe held continuously → acks exactly 8 clocks apart, each 1 clock wide, all at the cycle-7→0 edge.
